mem_bus_if: RTL



---
 rtl/mem_bus_if_pkg.sv | 21 ++
 rtl/mem_bus_if_if.sv | 39 +++
 rtl/mem_wait_timer.sv | 22 ++
 rtl/mem_bus_if.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the CPU-to-memory bus interface block.
package mem_bus_if_pkg;

  localparam int WORD_SIZE = 16;
  localparam logic [WORD_SIZE-1:0] DEF_ERR_DATA = 16'hFFFF;

  // Controller state encoding, also visible on the debug state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Latched operation type of the transaction in flight.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_bus_if_if.sv
// Bundle of CPU request lines and memory handshake lines for mem_bus_if.
interface mem_bus_if_if #(
  parameter int WORD_SIZE = mem_bus_if_pkg::WORD_SIZE
);
  // CPU side
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 mem_ready;
  logic                 busy;
  logic                 bus_error;
  // Memory side
  logic [WORD_SIZE-1:0] m_addr;
  logic                 m_read;
  logic                 m_write;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 m_ack;
  // Statistics
  logic [WORD_SIZE-1:0] rd_count;
  logic [WORD_SIZE-1:0] wr_count;

  // Handshake: a CPU request is a rising level on readM/writeM seen in IDLE;
  // the block answers with a single-cycle mem_ready. Toward memory, m_read or
  // m_write stays high and m_addr/m_wdata stay stable until a cycle whose
  // closing edge samples m_ack=1 (m_rdata is taken on that same edge) or the
  // wait budget runs out. m_ack in any other cycle has no effect.
  modport slave (
    input  readM, writeM, address, m_rdata, m_ack,
    output mem_ready, busy, bus_error, m_addr, m_read, m_write, m_wdata,
           rd_count, wr_count
  );

  modport master (
    output readM, writeM, address, m_rdata, m_ack,
    input  mem_ready, busy, bus_error, m_addr, m_read, m_write, m_wdata,
           rd_count, wr_count
  );
endinterface

// File: rtl/mem_wait_timer.sv
// 8-bit wait counter with clear/enable; o_tc flags the last allowed REQ cycle.
module mem_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam logic [7:0] TC_VAL = 8'(MAX_WAIT - 1);

  logic [7:0] r_cnt;

  // Count REQ cycles spent without an acknowledge.
  always_ff @(posedge Clk) begin
    if (Reset || i_clr) r_cnt <= 8'd0;
    else if (i_en)      r_cnt <= r_cnt + 8'd1;
  end

  assign o_tc = (r_cnt == TC_VAL);
endmodule

// File: rtl/mem_bus_if.sv
// CPU memory-port bridge: one request at a time, req/ack toward memory with a
// wait timeout, read data returned on the shared bus with a ready strobe.
module mem_bus_if #(
  parameter int                   WORD_SIZE = mem_bus_if_pkg::WORD_SIZE,
  parameter int                   MAX_WAIT  = 8,
  parameter logic [WORD_SIZE-1:0] ERR_DATA  = mem_bus_if_pkg::DEF_ERR_DATA
) (
  input  logic                   Clk,
  input  logic                   Reset,
  mem_bus_if_if.slave            bus,
  inout  wire  [WORD_SIZE-1:0]   data,
  output mem_bus_if_pkg::state_t o_dbg_state,
  output logic                   o_dbg_data_oe
);
  import mem_bus_if_pkg::*;

  state_t               r_state;
  state_t               w_next_state;
  op_t                  r_op;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_rd_cnt;
  logic [WORD_SIZE-1:0] r_wr_cnt;
  logic                 r_err;
  logic                 r_prev_req;
  logic                 r_acked;
  logic                 w_req;
  logic                 w_accept;
  logic                 w_tmr_clr;
  logic                 w_tmr_en;
  logic                 w_tmr_tc;
  logic                 w_data_oe;

  assign w_req    = bus.readM | bus.writeM;
  assign w_accept = (r_state == IDLE) && w_req && !r_prev_req;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tmr_tc)
  );

  // Request edge detector. It keeps sampling while Reset is high so a request
  // line held across a reset is not mistaken for a fresh request afterwards.
  always_ff @(posedge Clk) begin
    r_prev_req <= w_req;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and timer control; ack wins over a timeout on the same edge.
  always_comb begin
    w_next_state = r_state;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (bus.readM && bus.writeM) ? ERR : REQ;
          w_tmr_clr    = 1'b1;
        end
      end
      REQ: begin
        if (bus.m_ack || w_tmr_tc) w_next_state = RESP;
        else                       w_tmr_en     = 1'b1;
      end
      ERR:     w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Transaction latches, response data, sticky error and completion counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_op     <= OP_RD;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_acked  <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acked <= 1'b0;
            if (!(bus.readM && bus.writeM)) begin
              r_addr <= bus.address;
              if (bus.writeM) begin
                r_op    <= OP_WR;
                r_wdata <= data;
              end else begin
                r_op <= OP_RD;
              end
            end
          end
        end
        REQ: begin
          if (bus.m_ack) begin
            r_acked <= 1'b1;
            if (r_op == OP_RD) r_rdata <= bus.m_rdata;
          end else if (w_tmr_tc) begin
            r_err   <= 1'b1;
            r_rdata <= ERR_DATA;
          end
        end
        ERR: begin
          r_err   <= 1'b1;
          r_rdata <= ERR_DATA;
          r_op    <= OP_RD;
        end
        RESP: begin
          if (r_acked) begin
            if (r_op == OP_RD) r_rd_cnt <= r_rd_cnt + 1'b1;
            else               r_wr_cnt <= r_wr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_data_oe     = (r_state == RESP) && (r_op == OP_RD);
  assign data          = w_data_oe ? r_rdata : {WORD_SIZE{1'bz}};
  assign bus.m_addr    = r_addr;
  assign bus.m_wdata   = r_wdata;
  assign bus.m_read    = (r_state == REQ) && (r_op == OP_RD);
  assign bus.m_write   = (r_state == REQ) && (r_op == OP_WR);
  assign bus.mem_ready = (r_state == RESP);
  assign bus.busy      = (r_state == REQ) || (r_state == RESP);
  assign bus.bus_error = r_err;
  assign bus.rd_count  = r_rd_cnt;
  assign bus.wr_count  = r_wr_cnt;
  assign o_dbg_state   = r_state;
  assign o_dbg_data_oe = w_data_oe;
endmodule
